// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU sequencer/arbiter: opcodes, flag positions, FSM encoding.
package alu_arbiter_pkg;

  localparam logic [3:0] OP_ADD = 4'd3;
  localparam logic [3:0] OP_SUB = 4'd4;
  localparam logic [3:0] OP_MUL = 4'd5;
  localparam logic [3:0] OP_DIV = 4'd6;
  localparam logic [3:0] OP_AND = 4'd7;
  localparam logic [3:0] OP_OR  = 4'd8;
  localparam logic [3:0] OP_XOR = 4'd9;
  localparam logic [3:0] OP_SHL = 4'd10;
  localparam logic [3:0] OP_SHR = 4'd11;

  localparam int unsigned F_O = 3;
  localparam int unsigned F_C = 2;
  localparam int unsigned F_N = 1;
  localparam int unsigned F_Z = 0;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StCapture,
    StDone
  } state_e;

  function automatic logic op_legal(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_SHR);
  endfunction

  function automatic logic [1:0] id_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bus between the two ALU requesters and the arbiter.
interface alu_arbiter_if #(
  parameter int unsigned DATA_W = 16
) ();

  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [7:0]          req_opcode;
  logic [1:0]          req_ar;
  logic [2*DATA_W-1:0] req_src1;
  logic [2*DATA_W-1:0] req_src2;
  logic [1:0]          rsp_valid;
  logic [DATA_W-1:0]   rsp_data;
  logic [3:0]          rsp_flags;
  logic                rsp_err;

  modport master (
    output req_valid, req_opcode, req_ar, req_src1, req_src2,
    input  req_ready, rsp_valid, rsp_data, rsp_flags, rsp_err
  );

  modport slave (
    input  req_valid, req_opcode, req_ar, req_src1, req_src2,
    output req_ready, rsp_valid, rsp_data, rsp_flags, rsp_err
  );

endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant; last_grant resets to 1 so requester 0 wins the first tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic       grant,
  output logic       grant_valid
);

  logic last_grant_q;

  always_comb begin
    grant_valid = |req;
    grant       = (req == 2'b11) ? ~last_grant_q : req[1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else if (accept) begin
      last_grant_q <= grant;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Sequences the shared registered ALU for two requesters: accept, issue, capture, respond.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter bit          DIV0_TRAP = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  alu_arbiter_if.slave      bus,
  output logic              busy,
  output logic [3:0]        alu_opcode,
  output logic              alu_ar_flag,
  output logic [DATA_W-1:0] alu_src1,
  output logic [DATA_W-1:0] alu_src2,
  output logic              alu_out_en,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [3:0]        alu_flags
);

  state_e              state_q;
  logic                id_q;
  logic [1:0]          rsp_valid_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic [3:0]          rsp_flags_q;
  logic                rsp_err_q;

  logic                grant;
  logic                grant_valid;
  logic                accept;
  logic [3:0]          sel_op;
  logic                sel_ar;
  logic [DATA_W-1:0]   sel_src1;
  logic [DATA_W-1:0]   sel_src2;
  logic                sel_err;

  rr_arb2 u_rr_arb2 (
    .clk         (clk),
    .rst         (rst),
    .req         (bus.req_valid),
    .accept      (accept),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  always_comb begin
    sel_op   = grant ? bus.req_opcode[7:4] : bus.req_opcode[3:0];
    sel_ar   = bus.req_ar[grant];
    sel_src1 = grant ? bus.req_src1[2*DATA_W-1:DATA_W] : bus.req_src1[DATA_W-1:0];
    sel_src2 = grant ? bus.req_src2[2*DATA_W-1:DATA_W] : bus.req_src2[DATA_W-1:0];
    sel_err  = !op_legal(sel_op) || (DIV0_TRAP && (sel_op == OP_DIV) && (sel_src2 == '0));
    // grant always points at a valid requester, so grant_valid implies req_valid[grant]
    accept        = (state_q == StIdle) && !rst && grant_valid;
    bus.req_ready = accept ? id_onehot(grant) : 2'b00;
    busy          = (state_q != StIdle);
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_flags = rsp_flags_q;
  assign bus.rsp_err   = rsp_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      id_q        <= 1'b0;
      rsp_valid_q <= 2'b00;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
      rsp_err_q   <= 1'b0;
      alu_out_en  <= 1'b0;
      alu_opcode  <= '0;
      alu_ar_flag <= 1'b0;
      alu_src1    <= '0;
      alu_src2    <= '0;
    end else begin
      rsp_valid_q <= 2'b00;
      alu_out_en  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            id_q        <= grant;
            alu_opcode  <= sel_op;
            alu_ar_flag <= sel_ar;
            alu_src1    <= sel_src1;
            alu_src2    <= sel_src2;
            if (sel_err) begin
              // Trapped ops skip the ALU and answer on the very next cycle
              state_q     <= StDone;
              rsp_valid_q <= id_onehot(grant);
              rsp_data_q  <= '0;
              rsp_flags_q <= '0;
              rsp_err_q   <= 1'b1;
            end else begin
              state_q    <= StIssue;
              alu_out_en <= 1'b1;
            end
          end
        end
        StIssue: state_q <= StCapture;
        StCapture: begin
          rsp_data_q  <= alu_out;
          rsp_flags_q <= alu_flags;
          rsp_err_q   <= 1'b0;
          rsp_valid_q <= id_onehot(id_q);
          state_q     <= StDone;
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Sequences the shared 16-bit ALU and arbitrates it between two requesters: req 0 is the execute stage, req 1 is the address/auxiliary unit.
- Accepts one operation at a time with valid/ready, drives the ALU operand/opcode/out_en pins, and captures the registered ALU result and flags.
- Returns the result to the granting requester with a one-cycle response pulse.
- Traps illegal opcodes and divide-by-zero without touching the ALU.

Parameters:
- DATA_W, 16, operand/result width; must match the ALU.
- DIV0_TRAP, 1, 1 = divide with src2==0 is answered as an error without issuing to the ALU; 0 = issued normally.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_valid  in  2  per-requester request valid, bit n = requester n
- req_ready  out  2  per-requester accept; one-hot or zero
- req_opcode  in  8  {req1[3:0], req0[3:0]}
- req_ar  in  2  per-requester arithmetic-shift flag
- req_src1  in  32  {req1, req0} operand 1
- req_src2  in  32  {req1, req0} operand 2
- rsp_valid  out  2  one-cycle response pulse, bit n = requester n
- rsp_data  out  16  result, valid when rsp_valid != 0
- rsp_flags  out  4  O C N Z from the ALU; 0 on error
- rsp_err  out  1  illegal opcode or divide-by-zero
- busy  out  1  high whenever state != IDLE
- alu_opcode  out  4  to ALU
- alu_ar_flag  out  1  to ALU
- alu_src1  out  16  to ALU
- alu_src2  out  16  to ALU
- alu_out_en  out  1  to ALU, high for exactly one cycle per operation
- alu_out  in  16  ALU registered result
- alu_flags  in  4  ALU registered flags

Behaviour:
- Clock and reset: single clock `clk`; `rst` is synchronous and active-high.
- Reset (synchronous, rst high at a clk edge):
  - state=IDLE, rsp_valid=0, rsp_data=0, rsp_flags=0, rsp_err=0.
  - alu_out_en=0, alu_opcode/src regs=0, last_grant=1, so requester 0 wins first.
  - req_ready is forced 0 while rst is high.
- FSM states: IDLE, ISSUE, CAPTURE, DONE.
- IDLE:
  - Grant is combinational. Only one valid: grant it. Both valid: grant !last_grant (round-robin).
  - req_ready[grant]=1 only in IDLE and only if req_valid[grant].
  - Accept = valid & ready. On accept, latch opcode/ar/src1/src2 and the grant id, and set last_grant=grant.
  - Legal opcodes are 3..11 (ADD SUB MUL DIV AND OR XOR SHL SHR). Any other opcode, or opcode 6 with src2==0 when DIV0_TRAP=1, is an error: go to DONE with rsp_err=1, data=0, flags=0.
  - Otherwise go to ISSUE.
- ISSUE: alu_out_en=1 with latched operands stable; next state CAPTURE.
- CAPTURE: alu_out_en=0, operands still held. Register alu_out into rsp_data and alu_flags into rsp_flags, with rsp_err=0. Next state DONE.
- DONE: rsp_valid[id]=1 for this cycle only; next state IDLE.
- Latency, with accept in cycle T:
  - Normal operation: alu_out_en high in T+1, rsp_valid in T+3.
  - Error: rsp_valid in T+1.
  - Maximum throughput is one operation per 4 cycles; a new accept is possible in the cycle after DONE.
- No response backpressure: requesters must sample rsp_data/rsp_flags/rsp_err on the rsp_valid pulse.
- rsp_data/flags/err hold their value until the next response.
- A requester that deasserts req_valid without being accepted is not served. Requests never queue.
- Reset mid-operation (ISSUE/CAPTURE/DONE): the operation is dropped, no rsp_valid is produced, and alu_out_en is low from the next cycle.
- Starvation bound: with both requesters permanently valid, grants alternate 0,1,0,1…

Decomposition:
- Shared package holds:
  - ALU opcode constants (OP_ADD=3 … OP_SHR=11).
  - Flag bit indices (F_O=3, F_C=2, F_N=1, F_Z=0).
  - FSM state encoding.
- One natural sub-module: rr_arb2, the two-input round-robin grant using last_grant, purely combinational plus the last_grant register.
- The FSM and ALU drive logic stay in alu_arbiter.

Test Plan:
- After reset, req0 sends ADD 0x7FFF+0x0001 → alu_out_en pulses once at T+1; rsp_valid=2'b01 at T+3; rsp_data=0x8000; rsp_flags=4'b1010; rsp_err=0.
- req1 sends SUB 0x0005-0x0005 → rsp_valid=2'b10 at T+3; rsp_data=0x0000; rsp_flags=4'b0001.
- Both requesters valid continuously after reset with distinct ADDs → grant order 0,1,0,1; responses 4 cycles apart, each carrying the correct requester's result.
- req1 sends DIV src2=0 (DIV0_TRAP=1) → rsp_valid=2'b10 at T+1, rsp_err=1, rsp_data=0, rsp_flags=0, alu_out_en never asserted. Repeat with opcode 0xC → same error response.
- rst asserted during ISSUE → next cycle state=IDLE, no rsp_valid ever; the following req0 XOR 0xFF00^0x0FF0 → rsp_data=0xF0F0.
- Overlap: req0 held valid while busy → req_ready=0 in ISSUE/CAPTURE/DONE; accepted in the IDLE cycle right after DONE.
